frame_buffer_ctrl: RTL and testbench

- Triple-buffer manager for the DDR frame store.
- Hands the AXI write path a write base address, and the HDMI read path a read base address, for three equal-sized frame buffers.
- Commits a captured frame to "latest" only when the writer is between bursts; the reader always gets the newest complete frame and never a buffer being written.
- Sits between the camera/mixer frame strobes, the AXI write master's FRAME_BASE_ADDR, and the HDMI read DMA.

---
 rtl/fb_pkg.sv | 28 ++
 rtl/fb_addr_gen.sv | 38 +++
 rtl/frame_buffer_ctrl.sv | 158 +++++++++++++++
 tb/tb_frame_buffer_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the triple-buffered DDR frame store: buffer index type,
// controller state encodings and default buffer placement.
package fb_pkg;

    typedef logic [1:0] buf_idx_t;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } fb_state_t;

    localparam logic [31:0] FB_BASE_DEFAULT   = 32'h0100_0000;
    localparam logic [31:0] FB_STRIDE_DEFAULT = 32'd153600;

    localparam buf_idx_t W_RST_IDX = 2'd0;
    localparam buf_idx_t L_RST_IDX = 2'd1;
    localparam buf_idx_t R_RST_IDX = 2'd2;

    // Shift-add form of base + idx*stride; only indices 0..2 occur.
    function automatic logic [31:0] idx_to_addr(input logic [31:0] base,
                                                input logic [31:0] stride,
                                                input buf_idx_t    idx);
        logic [31:0] off;
        off = (idx[1] ? (stride << 1) : 32'd0) + (idx[0] ? stride : 32'd0);
        return base + off;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Registered buffer-index to byte-address conversion; one instance per
// frame-store port (writer and reader).
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter logic [31:0] FB_BASE   = FB_BASE_DEFAULT,
    parameter logic [31:0] FB_STRIDE = FB_STRIDE_DEFAULT,
    parameter buf_idx_t    RST_IDX   = 2'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  buf_idx_t    idx_i,
    output buf_idx_t    idx_o,
    output logic [31:0] addr_o
);

    buf_idx_t    idx_d, idx_q;
    logic [31:0] addr_d, addr_q;

    always_comb begin
        idx_d  = idx_i;
        addr_d = idx_to_addr(FB_BASE, FB_STRIDE, idx_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= RST_IDX;
            addr_q <= idx_to_addr(FB_BASE, FB_STRIDE, RST_IDX);
        end else begin
            idx_q  <= idx_d;
            addr_q <= addr_d;
        end
    end

    assign idx_o  = idx_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Triple-buffer manager: rotates writer/latest/reader buffer roles on frame
// commits and reader vsyncs. Define FB_STATUS_CNT_EN to add frame/drop counters.
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter logic [31:0] FB_BASE   = FB_BASE_DEFAULT,
    parameter logic [31:0] FB_STRIDE = FB_STRIDE_DEFAULT,
    parameter int          CNT_W     = 16
) (
    input  logic        clk_100Mhz,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_frame_done,
    input  logic        wr_idle,
    input  logic        rd_frame_start,
    output logic [31:0] wr_base_addr,
    output logic [31:0] rd_base_addr,
    output logic [1:0]  wr_buf_idx,
    output logic [1:0]  rd_buf_idx,
    output logic        rd_valid,
    output logic        fresh,
    output logic        swap_pending
`ifdef FB_STATUS_CNT_EN
    ,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
`endif
);

    buf_idx_t  w_d, w_q, l_d, l_q, r_d, r_q;
    logic      fresh_d, fresh_q;
    logic      rd_valid_d, rd_valid_q;
    logic      swap_pending_d, swap_pending_q;
    fb_state_t state_d, state_q;
    logic      commit, take;

    always_comb begin
        w_d        = w_q;
        l_d        = l_q;
        r_d        = r_q;
        fresh_d    = fresh_q;
        rd_valid_d = rd_valid_q;
        state_d    = state_q;
        commit     = 1'b0;
        take       = rd_frame_start & en;

        // A pending completion finishes on wr_idle whatever en is doing.
        case (state_q)
            S_RUN: begin
                if (wr_frame_done && en) begin
                    if (wr_idle) commit  = 1'b1;
                    else         state_d = S_PEND;
                end
            end
            S_PEND: begin
                if (wr_idle) begin
                    commit  = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        if (commit) begin
            w_d     = l_q;
            l_d     = w_q;
            fresh_d = 1'b1;
        end

        // The take sees the post-commit roles, so a same-cycle commit is consumed directly.
        if (take && fresh_d) begin
            r_d        = l_d;
            l_d        = r_q;
            fresh_d    = 1'b0;
            rd_valid_d = 1'b1;
        end

        swap_pending_d = (state_d == S_PEND);
    end

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            w_q            <= W_RST_IDX;
            l_q            <= L_RST_IDX;
            r_q            <= R_RST_IDX;
            fresh_q        <= 1'b0;
            rd_valid_q     <= 1'b0;
            swap_pending_q <= 1'b0;
            state_q        <= S_RUN;
        end else begin
            w_q            <= w_d;
            l_q            <= l_d;
            r_q            <= r_d;
            fresh_q        <= fresh_d;
            rd_valid_q     <= rd_valid_d;
            swap_pending_q <= swap_pending_d;
            state_q        <= state_d;
        end
    end

    assign fresh        = fresh_q;
    assign rd_valid     = rd_valid_q;
    assign swap_pending = swap_pending_q;

    fb_addr_gen #(
        .FB_BASE   (FB_BASE),
        .FB_STRIDE (FB_STRIDE),
        .RST_IDX   (W_RST_IDX)
    ) u_wr_addr (
        .clk    (clk_100Mhz),
        .rst    (rst),
        .idx_i  (w_q),
        .idx_o  (wr_buf_idx),
        .addr_o (wr_base_addr)
    );

    fb_addr_gen #(
        .FB_BASE   (FB_BASE),
        .FB_STRIDE (FB_STRIDE),
        .RST_IDX   (R_RST_IDX)
    ) u_rd_addr (
        .clk    (clk_100Mhz),
        .rst    (rst),
        .idx_i  (r_q),
        .idx_o  (rd_buf_idx),
        .addr_o (rd_base_addr)
    );

`ifdef FB_STATUS_CNT_EN
    logic             drop;
    logic [CNT_W-1:0] frame_cnt_d, frame_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d, drop_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        drop        = commit & fresh_q & ~take;
        frame_cnt_d = commit ? sat_inc(frame_cnt_q) : frame_cnt_q;
        drop_cnt_d  = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl: directed scenarios then random traffic, checked
// against a role-rotation reference model.
module tb_frame_buffer_ctrl;

    localparam logic [31:0] BASE   = 32'h0100_0000;
    localparam logic [31:0] STRIDE = 32'd153600;
    localparam int          CW     = 16;

    logic        clk = 1'b0;
    logic        rst, en, wr_frame_done, wr_idle, rd_frame_start;
    logic [31:0] wr_base_addr, rd_base_addr;
    logic [1:0]  wr_buf_idx, rd_buf_idx;
    logic        rd_valid, fresh, swap_pending;
`ifdef FB_STATUS_CNT_EN
    logic [CW-1:0] frame_cnt, drop_cnt;
`endif

    frame_buffer_ctrl #(.FB_BASE(BASE), .FB_STRIDE(STRIDE), .CNT_W(CW)) dut (
        .clk_100Mhz     (clk),
        .rst            (rst),
        .en             (en),
        .wr_frame_done  (wr_frame_done),
        .wr_idle        (wr_idle),
        .rd_frame_start (rd_frame_start),
        .wr_base_addr   (wr_base_addr),
        .rd_base_addr   (rd_base_addr),
        .wr_buf_idx     (wr_buf_idx),
        .rd_buf_idx     (rd_buf_idx),
        .rd_valid       (rd_valid),
        .fresh          (fresh),
        .swap_pending   (swap_pending)
`ifdef FB_STATUS_CNT_EN
        ,
        .frame_cnt      (frame_cnt),
        .drop_cnt       (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: buffer roles, freshness, pending completion, counters.
    int mW, mL, mR, mframe, mdrop;
    bit mfresh, mvalid, mpend;

    task automatic model_reset();
        mW = 0; mL = 1; mR = 2;
        mfresh = 0; mvalid = 0; mpend = 0;
        mframe = 0; mdrop = 0;
    endtask

    task automatic model_step(input bit done, input bit idle, input bit start, input bit ena);
        bit do_commit, do_take;
        int t;
        do_commit = 0;
        if (mpend) begin
            if (idle) begin do_commit = 1; mpend = 0; end
        end else if (done && ena) begin
            if (idle) do_commit = 1;
            else      mpend = 1;
        end
        do_take = start && ena;
        if (do_commit) begin
            t = mW; mW = mL; mL = t;
            if (mfresh && !do_take && mdrop < (1 << CW) - 1) mdrop++;
            if (mframe < (1 << CW) - 1) mframe++;
            mfresh = 1;
        end
        if (do_take && mfresh) begin
            t = mR; mR = mL; mL = t;
            mfresh = 0;
            mvalid = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int ew, input int er);
        chk("fresh", 32'(fresh), 32'(mfresh));
        chk("rd_valid", 32'(rd_valid), 32'(mvalid));
        chk("swap_pending", 32'(swap_pending), 32'(mpend));
        chk("wr_buf_idx", 32'(wr_buf_idx), 32'(ew));
        chk("rd_buf_idx", 32'(rd_buf_idx), 32'(er));
        chk("wr_base_addr", wr_base_addr, BASE + 32'(ew) * STRIDE);
        chk("rd_base_addr", rd_base_addr, BASE + 32'(er) * STRIDE);
        chk("idx_distinct", 32'(wr_buf_idx != rd_buf_idx && wr_buf_idx < 2'd3 && rd_buf_idx < 2'd3), 32'd1);
        chk("roles_perm", 32'(mW != mL && mW != mR && mL != mR), 32'd1);
`ifdef FB_STATUS_CNT_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(mframe));
        chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
`endif
    endtask

    // One clock: drive inputs, advance the model on the edge, sample 1 ns later.
    // Index/address outputs lag the role registers by one cycle.
    task automatic step(input bit done, input bit idle, input bit start, input bit ena);
        int ow, orr;
        wr_frame_done = done; wr_idle = idle; rd_frame_start = start; en = ena;
        @(posedge clk);
        ow = mW; orr = mR;
        model_step(done, idle, start, ena);
        #1;
        check_all(ow, orr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all(mW, mR);
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 0, 1);
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; wr_frame_done = 1'b0; wr_idle = 1'b1; rd_frame_start = 1'b0;
        #2;
        do_reset();
        chk("reset_wr_addr", wr_base_addr, 32'h0100_0000);
        chk("reset_rd_addr", rd_base_addr, 32'h0104_B000);

        // Immediate commit, then the reader takes it.
        step(1, 1, 0, 1);
        step(0, 1, 0, 1);
        chk("commit_wr_addr", wr_base_addr, 32'h0102_5800);
        step(0, 1, 1, 1);
        step(0, 1, 0, 1);
        chk("take_rd_addr", rd_base_addr, 32'h0100_0000);
        chk("take_rd_valid", 32'(rd_valid), 32'd1);

        // Deferred commit while the writer is busy, with an absorbed second pulse.
        do_reset();
        step(1, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(i == 4, 0, 0, 1);
        chk("pend_wr_addr", wr_base_addr, 32'h0100_0000);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        chk("pend_one_commit", wr_base_addr, 32'h0102_5800);

        // Two commits unread, then commit + take in the same cycle.
        do_reset();
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        step(0, 1, 0, 1);
        do_reset();
        step(1, 1, 0, 1);
        step(1, 1, 1, 1);
        step(0, 1, 0, 1);
        chk("same_cycle_rd_idx", 32'(rd_buf_idx), 32'd1);
        chk("same_cycle_wr_idx", 32'(wr_buf_idx), 32'd0);

        // Reset while a completion is pending; en=0 ignores strobes.
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        do_reset();
        step(1, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 1);

        // en dropped while pending still lets the commit complete.
        step(1, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);

        for (int i = 0; i < 400; i++)
            step($urandom_range(5) == 0, $urandom_range(9) < 6,
                 $urandom_range(4) == 0, $urandom_range(9) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
